avalon_slave_memory: RTL and testbench
======================================

# avalon_slave_memory

Avalon-MM burst-capable slave backed by an on-chip word-addressed RAM; the responder counterpart to the Avalon master bridge. It serves as the memory model behind that master in simulation and on-chip test systems. It accepts single and burst reads and writes, applies byte enables, and can inject backpressure through a stall input.

## Interface
Parameters:
- C_AVS_ADDR_WIDTH, 32, byte address width
- C_AVS_DATA_WIDTH, 32, data width in bits; a power of two, at least 8
- C_MEM_ADDR_WIDTH, 10, log2 of RAM depth in words
- C_AVS_BASE, 'h00000000, byte base address subtracted from avs_address

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESET  in  1  reset, asynchronous, active-high
- avs_address  in  C_AVS_ADDR_WIDTH  byte address; sampled on the first beat or command only
- avs_waitrequest  out  1  high means the current read/write is not accepted
- avs_byteenable  in  C_AVS_DATA_WIDTH/8  per-byte write enable
- avs_burstcount  in  8  beats; 0 encodes 256; sampled with the first beat or command
- avs_read  in  1  read command
- avs_readdata  out  C_AVS_DATA_WIDTH  read data
- avs_readdatavalid  out  1  readdata qualifier
- avs_write  in  1  write beat valid
- avs_writedata  in  C_AVS_DATA_WIDTH  write data
- stall_in  in  1  backpressure injection
- busy  out  1  high in any state other than IDLE

## Operation
- Word index = (avs_address − C_AVS_BASE) >> log2(C_AVS_DATA_WIDTH/8), truncated to C_MEM_ADDR_WIDTH bits. The index wraps modulo RAM depth. Low byte-offset bits are ignored.
- Beat counter: 9 bits, loaded with burstcount, or 256 when burstcount = 0.
- avs_waitrequest = ARESET | stall_in | (state == READ_BURST).
- States:
  - IDLE: a write is accepted when avs_write & !avs_waitrequest. The first beat is written, the address register is set to index+1, and remaining is set to count−1. If count = 1, stay in IDLE; otherwise go to WRITE_BURST. Else, a read is accepted when avs_read & !avs_waitrequest: the address register is set to index, remaining is set to count, and the state goes to READ_BURST.
  - WRITE_BURST: each accepted beat writes at the address register, then the register increments and remaining decrements. avs_address and avs_burstcount are ignored. On the beat where remaining = 1, return to IDLE. Cycles with avs_write low are idle gaps and do not abort the burst.
  - READ_BURST: one RAM read per cycle at the address register; the register increments and remaining decrements. On the cycle where remaining = 1, return to IDLE. stall_in does not pause returning data.
- If avs_read and avs_write are both high in IDLE, the write wins and the read stays pending.
- Writes honour byteenable per byte; disabled bytes keep their old value. An all-zero byteenable still consumes a beat.
- Reads ignore byteenable.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: avs_waitrequest 1, avs_readdatavalid 0, avs_readdata 0, busy 0, state IDLE, counters 0.
- Reset mid-burst: the burst aborts immediately and no further readdatavalid pulses occur. RAM writes already done are kept.
- Write: a beat accepted in cycle T is visible to any read command accepted at T+1 or later.
- Read: command accepted in cycle C, count N. Then:
  - avs_waitrequest is high during C+1..C+N.
  - avs_readdatavalid is high contiguously during C+2..C+N+1.
  - The next command can be accepted at C+N+1, overlapping the last data beat.
- A single read has 2-cycle command-to-data latency.
- Read-during-write to the same word cannot occur, because commands are serialized.
- stall_in takes effect combinationally in the same cycle; a beat presented during stall is not accepted and must be held by the master.

## Test plan
- Single write then read: write 0xDEADBEEF to byte address 0x10 with burstcount 1, then read 0x10 with burstcount 1 → readdatavalid exactly 2 cycles after the command, readdata 0xDEADBEEF, waitrequest high for 1 cycle.
- Write burst of 4 at 0x100 with data 1,2,3,4, with a 2-cycle avs_write gap after beat 2; then read burst of 4 → readdatavalid for 4 consecutive cycles with data 1,2,3,4; busy falls after write beat 4.
- Byte enables: write 0xFFFFFFFF, then write 0x00000000 with byteenable 4'b0101, then read → 0xFF00FF00.
- Wrap and 256-beat burst, with C_MEM_ADDR_WIDTH = 4: write burstcount 0 starting at word 15 with data = beat index → the burst takes 256 beats; afterwards word 15 = 240 and word 0 = 241. The read-back returns 256 beats.
- Stall and priority: hold stall_in high for 3 cycles with avs_read and avs_write both high → no acceptance during the stall. On release the write is accepted first; the read is accepted after the write burst completes.
- Reset mid-read: assert ARESET during cycle C+3 of an 8-beat read → readdatavalid drops that cycle and stays 0; after release waitrequest is low and busy is 0.

Source files
------------

// File: rtl/avalon_slave_memory.sv
// Avalon-MM burst-capable slave in front of a word-addressed on-chip RAM.
// Serialises single/burst reads and writes, applies byte enables, and lets stall_in inject backpressure.
module avalon_slave_memory #(
   parameter int C_AVS_ADDR_WIDTH = 32,
   parameter int C_AVS_DATA_WIDTH = 32,
   parameter int C_MEM_ADDR_WIDTH = 10,
   parameter logic [C_AVS_ADDR_WIDTH-1:0] C_AVS_BASE = '0
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [C_AVS_ADDR_WIDTH-1:0]   avs_address,
   output logic                          avs_waitrequest,
   input  logic [C_AVS_DATA_WIDTH/8-1:0] avs_byteenable,
   input  logic [7:0]                    avs_burstcount,
   input  logic                          avs_read,
   output logic [C_AVS_DATA_WIDTH-1:0]   avs_readdata,
   output logic                          avs_readdatavalid,
   input  logic                          avs_write,
   input  logic [C_AVS_DATA_WIDTH-1:0]   avs_writedata,
   input  logic                          stall_in,
   output logic                          busy
);

   localparam int BYTES = C_AVS_DATA_WIDTH / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int DEPTH = 1 << C_MEM_ADDR_WIDTH;
   localparam logic [C_MEM_ADDR_WIDTH-1:0] ADDR_ONE = C_MEM_ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WRITE_BURST = 2'd1,
      READ_BURST  = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [C_MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [8:0]                    remaining_q, remaining_d;
   logic [C_AVS_DATA_WIDTH-1:0]   readdata_q, readdata_d;
   logic                          readdatavalid_q, readdatavalid_d;
   logic                          busy_q, busy_d;
   logic [C_AVS_DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];

   logic [C_AVS_ADDR_WIDTH-1:0]   offset_s;
   logic [C_MEM_ADDR_WIDTH-1:0]   idx_s;
   logic [8:0]                    count_s;
   logic                          wr_en_s;
   logic [C_MEM_ADDR_WIDTH-1:0]   wr_addr_s;
   logic                          rd_en_s;
   logic                          unused_s;

   assign offset_s = avs_address - C_AVS_BASE;
   assign idx_s    = offset_s[OFF +: C_MEM_ADDR_WIDTH];
   assign count_s  = (avs_burstcount == 8'd0) ? 9'd256 : {1'b0, avs_burstcount};
   assign unused_s = ^offset_s;

   assign avs_waitrequest   = ARESET | stall_in | (state_q == READ_BURST);
   assign avs_readdata      = readdata_q;
   assign avs_readdatavalid = readdatavalid_q;
   assign busy              = busy_q;

   // Command acceptance, burst sequencing and read-data capture
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      remaining_d     = remaining_q;
      wr_en_s         = 1'b0;
      wr_addr_s       = addr_q;
      rd_en_s         = 1'b0;
      case (state_q)
         IDLE: begin
            // Write has priority; a simultaneous read stays pending until the write finishes
            if (avs_write && !avs_waitrequest) begin
               wr_en_s     = 1'b1;
               wr_addr_s   = idx_s;
               addr_d      = idx_s + ADDR_ONE;
               remaining_d = count_s - 9'd1;
               if (count_s == 9'd1) begin
                  state_d = IDLE;
               end else begin
                  state_d = WRITE_BURST;
               end
            end else if (avs_read && !avs_waitrequest) begin
               addr_d      = idx_s;
               remaining_d = count_s;
               state_d     = READ_BURST;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE_BURST: begin
            if (avs_write && !avs_waitrequest) begin
               wr_en_s     = 1'b1;
               addr_d      = addr_q + ADDR_ONE;
               remaining_d = remaining_q - 9'd1;
               if (remaining_q == 9'd1) begin
                  state_d = IDLE;
               end else begin
                  state_d = WRITE_BURST;
               end
            end else begin
               state_d = WRITE_BURST;
            end
         end
         READ_BURST: begin
            rd_en_s     = 1'b1;
            addr_d      = addr_q + ADDR_ONE;
            remaining_d = remaining_q - 9'd1;
            if (remaining_q == 9'd1) begin
               state_d = IDLE;
            end else begin
               state_d = READ_BURST;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      readdatavalid_d = rd_en_s;
      readdata_d      = rd_en_s ? mem_q[addr_q] : readdata_q;
      busy_d          = (state_d != IDLE);
   end

   // Control and output registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q         <= IDLE;
         addr_q          <= {C_MEM_ADDR_WIDTH{1'b0}};
         remaining_q     <= 9'd0;
         readdata_q      <= {C_AVS_DATA_WIDTH{1'b0}};
         readdatavalid_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         remaining_q     <= remaining_d;
         readdata_q      <= readdata_d;
         readdatavalid_q <= readdatavalid_d;
         busy_q          <= busy_d;
      end
   end

   // RAM write port; contents are deliberately left unreset
   always_ff @(posedge ACLK) begin
      if (wr_en_s) begin
         for (int b = 0; b < BYTES; b++) begin
            if (avs_byteenable[b]) begin
               mem_q[wr_addr_s][b*8 +: 8] <= avs_writedata[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_avalon_slave_memory.sv
// Directed bench for avalon_slave_memory: a cycle-accurate vector table plus
// hand-written sequences for the 256-beat wrapping burst and reset in mid-read.
module tb_avalon_slave_memory;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [31:0] avs_address;
   logic        avs_waitrequest;
   logic [3:0]  avs_byteenable;
   logic [7:0]  avs_burstcount;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        stall_in;
   logic        busy;

   int checks = 0;
   int errors = 0;

   avalon_slave_memory #(
      .C_AVS_ADDR_WIDTH(32),
      .C_AVS_DATA_WIDTH(32),
      .C_MEM_ADDR_WIDTH(4),
      .C_AVS_BASE(32'h0000_0000)
   ) dut (
      .ACLK             (ACLK),
      .ARESET           (ARESET),
      .avs_address      (avs_address),
      .avs_waitrequest  (avs_waitrequest),
      .avs_byteenable   (avs_byteenable),
      .avs_burstcount   (avs_burstcount),
      .avs_read         (avs_read),
      .avs_readdata     (avs_readdata),
      .avs_readdatavalid(avs_readdatavalid),
      .avs_write        (avs_write),
      .avs_writedata    (avs_writedata),
      .stall_in         (stall_in),
      .busy             (busy)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [7:0]  bc;
      logic [31:0] wd;
      logic        st;
      logic        e_wait;
      logic        e_busy;
      logic        e_rdv;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t tbl [0:40];

   function automatic vec_t mk(logic wr, logic rd, logic [31:0] addr, logic [3:0] be,
                               logic [7:0] bc, logic [31:0] wd, logic st,
                               logic ew, logic eb, logic ev, logic [31:0] ed);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = addr; v.be = be; v.bc = bc; v.wd = wd; v.st = st;
      v.e_wait = ew; v.e_busy = eb; v.e_rdv = ev; v.e_rdata = ed;
      return v;
   endfunction

   function automatic vec_t idle(logic ew, logic eb, logic ev, logic [31:0] ed);
      return mk(1'b0, 1'b0, 32'h0, 4'h0, 8'd0, 32'h0, 1'b0, ew, eb, ev, ed);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [3:0] be, input logic [7:0] bc, input logic [31:0] wd,
                        input logic st);
      avs_write = wr; avs_read = rd; avs_address = addr; avs_byteenable = be;
      avs_burstcount = bc; avs_writedata = wd; stall_in = st;
   endtask

   initial begin
      int beats;
      int first_k;
      int last_k;
      logic [31:0] exp_d;

      // single write/read, burst with gap, byte enables, stall priority, back-to-back read
      tbl[0]  = mk(1'b1, 1'b0, 32'h10, 4'hF, 8'd1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[1]  = mk(1'b0, 1'b1, 32'h10, 4'hF, 8'd1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[2]  = idle(1'b1, 1'b1, 1'b0, 32'h0);
      tbl[3]  = idle(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      tbl[4]  = idle(1'b0, 1'b0, 1'b0, 32'h0);
      tbl[5]  = mk(1'b1, 1'b0, 32'h100, 4'hF, 8'd4, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[6]  = mk(1'b1, 1'b0, 32'h0, 4'hF, 8'd0, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tbl[7]  = idle(1'b0, 1'b1, 1'b0, 32'h0);
      tbl[8]  = idle(1'b0, 1'b1, 1'b0, 32'h0);
      tbl[9]  = mk(1'b1, 1'b0, 32'h0, 4'hF, 8'd0, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tbl[10] = mk(1'b1, 1'b0, 32'h0, 4'hF, 8'd0, 32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tbl[11] = idle(1'b0, 1'b0, 1'b0, 32'h0);
      tbl[12] = mk(1'b0, 1'b1, 32'h100, 4'hF, 8'd4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[13] = idle(1'b1, 1'b1, 1'b0, 32'h0);
      tbl[14] = idle(1'b1, 1'b1, 1'b1, 32'd1);
      tbl[15] = idle(1'b1, 1'b1, 1'b1, 32'd2);
      tbl[16] = idle(1'b1, 1'b1, 1'b1, 32'd3);
      tbl[17] = idle(1'b0, 1'b0, 1'b1, 32'd4);
      tbl[18] = idle(1'b0, 1'b0, 1'b0, 32'h0);
      tbl[19] = mk(1'b1, 1'b0, 32'h20, 4'hF, 8'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[20] = mk(1'b1, 1'b0, 32'h22, 4'h5, 8'd1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[21] = mk(1'b0, 1'b1, 32'h20, 4'h0, 8'd1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[22] = idle(1'b1, 1'b1, 1'b0, 32'h0);
      tbl[23] = idle(1'b0, 1'b0, 1'b1, 32'hFF00FF00);
      tbl[24] = mk(1'b1, 1'b0, 32'h20, 4'h0, 8'd1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[25] = mk(1'b0, 1'b1, 32'h20, 4'hF, 8'd1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[26] = idle(1'b1, 1'b1, 1'b0, 32'h0);
      tbl[27] = idle(1'b0, 1'b0, 1'b1, 32'hFF00FF00);
      tbl[28] = idle(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 29; i <= 31; i++) begin
         tbl[i] = mk(1'b1, 1'b1, 32'h30, 4'hF, 8'd2, 32'hA1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      end
      tbl[32] = mk(1'b1, 1'b1, 32'h30, 4'hF, 8'd2, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[33] = mk(1'b1, 1'b1, 32'h30, 4'hF, 8'd2, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tbl[34] = mk(1'b0, 1'b1, 32'h30, 4'hF, 8'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[35] = mk(1'b0, 1'b0, 32'h0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      tbl[36] = mk(1'b0, 1'b0, 32'h0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA1);
      tbl[37] = mk(1'b0, 1'b1, 32'h10, 4'hF, 8'd1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA2);
      tbl[38] = idle(1'b1, 1'b1, 1'b0, 32'h0);
      tbl[39] = idle(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      tbl[40] = idle(1'b0, 1'b0, 1'b0, 32'h0);

      ARESET = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 4'h0, 8'd0, 32'h0, 1'b0);
      repeat (3) @(posedge ACLK);
      #2;
      check("reset waitrequest", {31'd0, avs_waitrequest}, 32'd1);
      check("reset readdatavalid", {31'd0, avs_readdatavalid}, 32'd0);
      check("reset readdata", avs_readdata, 32'h0);
      check("reset busy", {31'd0, busy}, 32'd0);
      @(posedge ACLK);
      #1 ARESET = 1'b0;

      for (int i = 0; i <= 40; i++) begin
         @(posedge ACLK);
         #1;
         drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].be, tbl[i].bc, tbl[i].wd, tbl[i].st);
         #1;
         check($sformatf("row%0d waitrequest", i), {31'd0, avs_waitrequest}, {31'd0, tbl[i].e_wait});
         check($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
         check($sformatf("row%0d readdatavalid", i), {31'd0, avs_readdatavalid}, {31'd0, tbl[i].e_rdv});
         if (tbl[i].e_rdv) begin
            check($sformatf("row%0d readdata", i), avs_readdata, tbl[i].e_rdata);
         end
      end

      // 256-beat write burst starting at word 15 of a 16-word RAM, data = beat index
      for (int i = 0; i < 256; i++) begin
         @(posedge ACLK);
         #1;
         if (i == 0) drive(1'b1, 1'b0, 32'h3C, 4'hF, 8'd0, 32'd0, 1'b0);
         else        drive(1'b1, 1'b0, 32'hFFFF_FFF0, 4'hF, 8'd5, i, 1'b0);
         #1;
         check($sformatf("wrap beat%0d busy", i), {31'd0, busy}, (i == 0) ? 32'd0 : 32'd1);
      end
      @(posedge ACLK);
      #1;
      drive(1'b1, 1'b0, 32'h0, 4'hF, 8'd1, 32'hBAD0BAD0, 1'b1);
      #1;
      check("wrap end busy", {31'd0, busy}, 32'd0);

      @(posedge ACLK);
      #1;
      drive(1'b0, 1'b1, 32'h3C, 4'hF, 8'd0, 32'h0, 1'b0);
      beats = 0; first_k = -1; last_k = -1;
      for (int k = 1; k <= 300; k++) begin
         @(posedge ACLK);
         #1;
         drive(1'b0, 1'b0, 32'h0, 4'h0, 8'd0, 32'h0, 1'b0);
         #1;
         if (avs_readdatavalid) begin
            exp_d = 32'd240 + (beats % 16);
            check($sformatf("wrap read beat%0d", beats), avs_readdata, exp_d);
            if (first_k < 0) first_k = k;
            last_k = k;
            beats++;
         end
      end
      check("wrap read beat count", beats, 32'd256);
      check("wrap read first beat cycle", first_k, 32'd2);
      check("wrap read last beat cycle", last_k, 32'd257);

      // reset during cycle C+3 of an 8-beat read
      @(posedge ACLK);
      #1;
      drive(1'b0, 1'b1, 32'h0, 4'hF, 8'd8, 32'h0, 1'b0);
      #1;
      check("rstmid accept waitrequest", {31'd0, avs_waitrequest}, 32'd0);
      @(posedge ACLK);
      #1;
      drive(1'b0, 1'b0, 32'h0, 4'h0, 8'd0, 32'h0, 1'b0);
      #1;
      check("rstmid C+1 waitrequest", {31'd0, avs_waitrequest}, 32'd1);
      @(posedge ACLK);
      #2;
      check("rstmid C+2 readdatavalid", {31'd0, avs_readdatavalid}, 32'd1);
      check("rstmid C+2 readdata", avs_readdata, 32'd241);
      @(posedge ACLK);
      #1 ARESET = 1'b1;
      #1;
      check("rstmid C+3 readdatavalid", {31'd0, avs_readdatavalid}, 32'd0);
      @(posedge ACLK);
      #1;
      check("rstmid held readdatavalid", {31'd0, avs_readdatavalid}, 32'd0);
      ARESET = 1'b0;
      #1;
      check("rstmid release waitrequest", {31'd0, avs_waitrequest}, 32'd0);
      check("rstmid release busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 10; k++) begin
         @(posedge ACLK);
         #2;
         check($sformatf("rstmid after%0d readdatavalid", k), {31'd0, avs_readdatavalid}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
